best_neighbor_scanner: RTL and testbench

Sequential table scanner that sits directly upstream of the 2048x8 byte-addressed node memory and drives its read port. On a start pulse it reads neighborCount, walks the qValue table to find the neighbor with the highest Q-value, then fetches that neighbor's neighborID. It returns index, Q-value and ID to the routing FSM. The memory is big-endian with 16-bit words at even addresses and a combinational read, so the scanner reads one word per cycle.

---
 rtl/best_neighbor_scanner_pkg.sv | 37 +++
 rtl/best_neighbor_scanner_if.sv | 31 +++
 rtl/best_neighbor_scanner_max_tracker.sv | 55 +++++
 rtl/best_neighbor_scanner.sv | 153 +++++++++++++++
 tb/tb_best_neighbor_scanner.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/best_neighbor_scanner_pkg.sv
// Shared memory map, widths and FSM encoding for the best-neighbor scanner.
// The node memory is 2048 bytes, big-endian, read one 16-bit word per cycle.
package best_neighbor_scanner_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int WORD_WIDTH    = 16;
    localparam int MEM_DEPTH     = 2048;
    localparam int MAX_NEIGHBORS = 64;
    localparam int IDX_W         = 6;
    localparam int CNT_W         = 7;

    localparam logic [ADDR_W-1:0] NBR_CNT_ADDR = 16'h068A;
    localparam logic [ADDR_W-1:0] QVAL_BASE    = 16'h01C8;
    localparam logic [ADDR_W-1:0] NBR_ID_BASE  = 16'h0048;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_COUNT = 3'd1,
        ST_RD_Q     = 3'd2,
        ST_RD_ID    = 3'd3,
        ST_DONE     = 3'd4
    } scan_state_e;

    // Saturate a raw neighborCount word to the table capacity.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [DATA_W-1:0] raw,
                                                     input logic [DATA_W-1:0] limit);
        logic [CNT_W-1:0] result;
        if (raw > limit) begin
            result = limit[CNT_W-1:0];
        end else begin
            result = raw[CNT_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/best_neighbor_scanner_if.sv
// Request/result and memory read-port bundle between the scanner (master)
// and its surroundings: routing FSM plus node memory (slave).
interface best_neighbor_scanner_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 6
);
    logic              start;
    logic              busy;
    logic              done;
    logic              found;
    logic [IDX_W-1:0]  best_idx;
    logic [DATA_W-1:0] best_q;
    logic [DATA_W-1:0] best_id;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_data_in;

    modport master (
        input  start, mem_data_in,
        output busy, done, found, best_idx, best_q, best_id,
               mem_req, mem_address, mem_wr_en
    );

    modport slave (
        output start, mem_data_in,
        input  busy, done, found, best_idx, best_q, best_id,
               mem_req, mem_address, mem_wr_en
    );
endinterface

// File: rtl/best_neighbor_scanner_max_tracker.sv
// Registered running maximum with index capture. The first sample always
// loads; later samples replace only when strictly greater, so ties keep the lowest index.
module best_neighbor_scanner_max_tracker #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic              first,
    input  logic [DATA_W-1:0] value,
    input  logic [IDX_W-1:0]  index,
    output logic [DATA_W-1:0] max_value,
    output logic [IDX_W-1:0]  max_index,
    output logic [DATA_W-1:0] next_value,
    output logic [IDX_W-1:0]  next_index
);

    logic [DATA_W-1:0] max_value_r;
    logic [IDX_W-1:0]  max_index_r;
    logic              take_s;

    // Next running max; exposed so the caller can use the final-cycle winner immediately.
    always_comb begin
        take_s     = 1'b0;
        next_value = max_value_r;
        next_index = max_index_r;
        if (en && (first || (value > max_value_r))) begin
            take_s     = 1'b1;
            next_value = value;
            next_index = index;
        end else begin
            take_s     = 1'b0;
        end
    end

    // Running max registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            max_value_r <= {DATA_W{1'b0}};
            max_index_r <= {IDX_W{1'b0}};
        end else if (clear) begin
            max_value_r <= {DATA_W{1'b0}};
            max_index_r <= {IDX_W{1'b0}};
        end else if (take_s) begin
            max_value_r <= next_value;
            max_index_r <= next_index;
        end
    end

    assign max_value = max_value_r;
    assign max_index = max_index_r;

endmodule

// File: rtl/best_neighbor_scanner.sv
// Scans the qValue table for the highest-Q neighbor, then fetches its
// neighborID. Drives the node memory read port one word per cycle while busy.
module best_neighbor_scanner
    import best_neighbor_scanner_pkg::*;
#(
    parameter int                ADDR_W        = best_neighbor_scanner_pkg::ADDR_W,
    parameter int                DATA_W        = best_neighbor_scanner_pkg::DATA_W,
    parameter int                MAX_NEIGHBORS = best_neighbor_scanner_pkg::MAX_NEIGHBORS,
    parameter logic [ADDR_W-1:0] NBR_CNT_ADDR  = best_neighbor_scanner_pkg::NBR_CNT_ADDR,
    parameter logic [ADDR_W-1:0] QVAL_BASE     = best_neighbor_scanner_pkg::QVAL_BASE,
    parameter logic [ADDR_W-1:0] NBR_ID_BASE   = best_neighbor_scanner_pkg::NBR_ID_BASE
) (
    input  logic                     clock,
    input  logic                     reset,
    best_neighbor_scanner_if.master  bus
);

    scan_state_e       state_r;
    scan_state_e       state_nx;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [CNT_W-1:0]  i_r;
    logic              last_s;
    logic [ADDR_W-1:0] mem_address_r;
    logic              busy_r;
    logic              done_r;
    logic              found_r;
    logic [DATA_W-1:0] best_id_r;
    logic [DATA_W-1:0] max_value_s;
    logic [IDX_W-1:0]  max_index_s;
    logic [DATA_W-1:0] next_value_s;
    logic [IDX_W-1:0]  next_index_s;

    assign cnt_s  = clamp_count(bus.mem_data_in, DATA_W'(MAX_NEIGHBORS));
    assign last_s = (i_r == (cnt_r - 7'd1));

    best_neighbor_scanner_max_tracker #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_max_tracker (
        .clock      (clock),
        .reset      (reset),
        .clear      (state_r == ST_RD_COUNT),
        .en         (state_r == ST_RD_Q),
        .first      (i_r == 7'd0),
        .value      (bus.mem_data_in),
        .index      (i_r[IDX_W-1:0]),
        .max_value  (max_value_s),
        .max_index  (max_index_s),
        .next_value (next_value_s),
        .next_index (next_index_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_RD_COUNT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_RD_COUNT: begin
                if (cnt_s == 7'd0) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_RD_Q;
                end
            end
            ST_RD_Q: begin
                if (last_s) begin
                    state_nx = ST_RD_ID;
                end else begin
                    state_nx = ST_RD_Q;
                end
            end
            ST_RD_ID: state_nx = ST_RD_ID == state_r ? ST_DONE : ST_IDLE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Datapath: address sequencing, count/index, status flags and the fetched ID.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r         <= {CNT_W{1'b0}};
            i_r           <= {CNT_W{1'b0}};
            mem_address_r <= {ADDR_W{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            found_r       <= 1'b0;
            best_id_r     <= {DATA_W{1'b0}};
        end else begin
            busy_r <= (state_nx == ST_RD_COUNT) || (state_nx == ST_RD_Q) ||
                      (state_nx == ST_RD_ID);
            done_r <= (state_nx == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        mem_address_r <= NBR_CNT_ADDR;
                    end
                end
                ST_RD_COUNT: begin
                    cnt_r   <= cnt_s;
                    i_r     <= {CNT_W{1'b0}};
                    found_r <= 1'b0;
                    if (cnt_s != 7'd0) begin
                        mem_address_r <= QVAL_BASE;
                    end
                end
                ST_RD_Q: begin
                    // The winner including this cycle's entry selects the ID word.
                    if (last_s) begin
                        mem_address_r <= NBR_ID_BASE +
                            {{(ADDR_W-IDX_W-1){1'b0}}, next_index_s, 1'b0};
                    end else begin
                        i_r           <= i_r + 7'd1;
                        mem_address_r <= mem_address_r + ADDR_W'(2);
                    end
                end
                ST_RD_ID: begin
                    best_id_r <= bus.mem_data_in;
                    found_r   <= 1'b1;
                end
                default: begin
                    found_r <= found_r;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.mem_req     = busy_r;
    assign bus.done        = done_r;
    assign bus.found       = found_r;
    assign bus.best_idx    = max_index_s;
    assign bus.best_q      = max_value_s;
    assign bus.best_id     = best_id_r;
    assign bus.mem_address = mem_address_r;
    assign bus.mem_wr_en   = 1'b0;

endmodule

// File: tb/tb_best_neighbor_scanner.sv
// Scoreboard bench: directed scans push expected results; a negedge monitor
// checks each done pulse, per-cycle port invariants and the read-address trace.
module tb_best_neighbor_scanner;
    import best_neighbor_scanner_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    best_neighbor_scanner_if bus ();

    best_neighbor_scanner dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:2047];
    assign bus.mem_data_in = {mem[bus.mem_address[10:0]], mem[{bus.mem_address[10:1], 1'b1}]};

    typedef struct {
        logic        found;
        logic [5:0]  idx;
        logic [15:0] q;
        logic [15:0] id;
        logic        chk_id;
        int          lat;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] trace [$];
    int          checks    = 0;
    int          passes    = 0;
    int          cyc       = 0;
    int          start_cyc = 0;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: invariants every cycle, address trace while busy, scoreboard on done.
    always @(negedge clock) begin
        check("mem_wr_en_zero", 32'(bus.mem_wr_en), 32'd0);
        check("mem_req_eq_busy", 32'(bus.mem_req), 32'(bus.busy));
        if (bus.busy) trace.push_back(bus.mem_address);
        if (bus.done) begin
            check("done_one_cycle", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1, expected no done");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("found", 32'(bus.found), 32'(e.found));
                check("best_idx", 32'(bus.best_idx), 32'(e.idx));
                check("best_q", 32'(bus.best_q), 32'(e.q));
                if (e.chk_id) check("best_id", 32'(bus.best_id), 32'(e.id));
                check("latency", 32'(cyc - start_cyc), 32'(e.lat));
            end
        end
        prev_done <= bus.done;
    end

    task automatic wr_word(input int addr, input logic [15:0] data);
        mem[addr]     = data[15:8];
        mem[addr + 1] = data[7:0];
    endtask

    task automatic wr_q(input int i, input logic [15:0] v);
        wr_word(int'(QVAL_BASE) + 2 * i, v);
    endtask

    task automatic wr_id(input int i, input logic [15:0] v);
        wr_word(int'(NBR_ID_BASE) + 2 * i, v);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        trace.delete();
        start_cyc = cyc;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic run_scan(input logic f, input logic [5:0] idx, input logic [15:0] q,
                            input logic [15:0] id, input logic cid, input int lat);
        exp_t e;
        e.found = f; e.idx = idx; e.q = q; e.id = id; e.chk_id = cid; e.lat = lat;
        exp_q.push_back(e);
        pulse_start();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clock);
        check("scan_completes", 32'(exp_q.size()), 32'd0);
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_found"}, 32'(bus.found), 32'd0);
        check({tag, "_idx"}, 32'(bus.best_idx), 32'd0);
        check({tag, "_q"}, 32'(bus.best_q), 32'd0);
        check({tag, "_id"}, 32'(bus.best_id), 32'd0);
        check({tag, "_addr"}, 32'(bus.mem_address), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // Base table: q[i]=16-i, id[i]=i, count 16.
        for (int i = 0; i < 16; i++) begin
            wr_q(i, 16'(16 - i));
            wr_id(i, 16'(i));
        end
        wr_word(int'(NBR_CNT_ADDR), 16'd16);
        run_scan(1'b1, 6'd0, 16'd16, 16'd0, 1'b1, 19);

        // Mid-table winner and full address trace.
        wr_q(5, 16'h00FF);
        wr_id(5, 16'h0042);
        run_scan(1'b1, 6'd5, 16'h00FF, 16'h0042, 1'b1, 19);
        check("trace_len", 32'(trace.size()), 32'd18);
        if (trace.size() == 18) begin
            check("trace_count_addr", 32'(trace[0]), 32'h068A);
            for (int k = 0; k < 16; k++)
                check("trace_q_addr", 32'(trace[k + 1]), 32'h01C8 + 32'(2 * k));
            check("trace_id_addr", 32'(trace[17]), 32'h0052);
        end

        // Ties: lowest index wins.
        wr_q(5, 16'd11);
        wr_id(5, 16'd5);
        wr_q(3, 16'd16);
        run_scan(1'b1, 6'd0, 16'd16, 16'd0, 1'b1, 19);
        wr_q(9, 16'h0080);
        wr_q(7, 16'h0080);
        run_scan(1'b1, 6'd7, 16'h0080, 16'd7, 1'b1, 19);

        // Empty table: no qValue reads.
        wr_word(int'(NBR_CNT_ADDR), 16'd0);
        run_scan(1'b0, 6'd0, 16'd0, 16'd0, 1'b0, 2);
        check("empty_trace_len", 32'(trace.size()), 32'd1);

        // Oversized count clamps to 64; winner on the final entry.
        wr_q(63, 16'h1234);
        wr_id(63, 16'hBEEF);
        wr_word(int'(NBR_CNT_ADDR), 16'd200);
        run_scan(1'b1, 6'd63, 16'h1234, 16'hBEEF, 1'b1, 67);
        check("clamp_trace_len", 32'(trace.size()), 32'd66);
        if (trace.size() == 66) begin
            check("clamp_last_q_addr", 32'(trace[64]), 32'h0246);
            check("clamp_id_addr", 32'(trace[65]), 32'h00C6);
        end

        // Reset during RD_Q at i=7: silent return to all-zero idle.
        wr_word(int'(NBR_CNT_ADDR), 16'd16);
        pulse_start();
        begin
            int k;
            k = 0;
            while (bus.mem_address != 16'h01D6 && k < 50) begin
                @(negedge clock);
                k++;
            end
            check("reach_i7", 32'(bus.mem_address), 32'h01D6);
        end
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("midscan_reset");
        reset = 1'b0;
        run_scan(1'b1, 6'd7, 16'h0080, 16'd7, 1'b1, 19);

        // Start while busy and during DONE is ignored.
        begin
            exp_t e;
            int   k;
            e.found = 1'b1; e.idx = 6'd7; e.q = 16'h0080; e.id = 16'd7; e.chk_id = 1'b1; e.lat = 19;
            exp_q.push_back(e);
            pulse_start();
            repeat (4) @(negedge clock);
            bus.start = 1'b1;
            @(negedge clock);
            bus.start = 1'b0;
            k = 0;
            while (!bus.done && k < 100) begin
                @(negedge clock);
                k++;
            end
            check("done_seen", 32'(bus.done), 32'd1);
            bus.start = 1'b1;
            @(negedge clock);
            bus.start = 1'b0;
            check("start_in_done_ignored", 32'(bus.busy), 32'd0);
            repeat (30) @(negedge clock);
            check("no_second_scan_busy", 32'(bus.busy), 32'd0);
            check("no_pending_expect", 32'(exp_q.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
